// File: rtl/cpu_seq_core.sv
// Control core of the 8-bit CPU: microcycle sequencer, program counter and ALU.
// Micro-state is decoded combinationally from the instruction register and cycle count.
module cpu_seq_core (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic [7:0] bus_in,
    input  logic [7:0] rega,
    input  logic [7:0] regb,
    input  logic       cin,
    output logic [3:0] state,
    output logic [3:0] cycle,
    output logic [7:0] pc,
    output logic [7:0] alu_out,
    output logic       cout,
    output logic       eq_zero,
    output logic       jump_allowed
);

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;

    typedef enum logic [SW-1:0] {
        S_FETCH_PC   = 4'd0,
        S_FETCH_INST = 4'd1,
        S_HALT       = 4'd2,
        S_LOAD_ADDR  = 4'd3,
        S_RAM_A      = 4'd4,
        S_RAM_B      = 4'd5,
        S_STORE_A    = 4'd6,
        S_ALU_OP     = 4'd7,
        S_OUT_A      = 4'd8,
        S_JUMP       = 4'd9,
        S_LDI        = 4'd10,
        S_MOV_FETCH  = 4'd11,
        S_MOV_LOAD   = 4'd12,
        S_MOV_STORE  = 4'd13,
        S_NEXT       = 4'd15
    } state_e;

    logic [SW-1:0] cycle_q, cycle_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [SW-1:0] step;
    state_e        state_c;
    state_e        mem_state;
    logic          mov_memory;
    logic [DW:0]   alu_res;

    assign eq_zero      = (rega == 8'h00);
    assign jump_allowed = (opcode == 8'h06)
                        | ((opcode == 8'h07) & eq_zero)
                        | ((opcode == 8'h08) & ~eq_zero);
    assign mov_memory   = (opcode[5:3] == 3'b111) | (opcode[2:0] == 3'b111);
    assign step         = cycle_q - SW'(2);

    // Micro-state decode: two fetch cycles, then the opcode's step list, then NEXT.
    always_comb begin
        state_c   = S_NEXT;
        mem_state = S_RAM_A;
        case (opcode[1:0])
            2'b10:   mem_state = S_RAM_B;
            2'b11:   mem_state = S_STORE_A;
            default: mem_state = S_RAM_A;
        endcase
        if (cycle_q == SW'(0)) begin
            state_c = S_FETCH_PC;
        end else if (cycle_q == SW'(1)) begin
            state_c = S_FETCH_INST;
        end else begin
            casez (opcode)
                8'h01, 8'h02, 8'h03: begin
                    if (step == SW'(0))      state_c = S_FETCH_PC;
                    else if (step == SW'(1)) state_c = S_LOAD_ADDR;
                    else if (step == SW'(2)) state_c = mem_state;
                end
                8'h04: begin
                    if (step == SW'(0)) state_c = S_OUT_A;
                end
                8'h05: begin
                    if (step == SW'(0)) state_c = S_HALT;
                end
                8'h06, 8'h07, 8'h08: begin
                    if (step == SW'(0))      state_c = S_FETCH_PC;
                    else if (step == SW'(1)) state_c = S_JUMP;
                end
                8'b0001_0???: begin
                    if (step == SW'(0))      state_c = S_FETCH_PC;
                    else if (step == SW'(1)) state_c = S_LDI;
                end
                8'b01??_????: begin
                    if (step == SW'(0))      state_c = S_MOV_FETCH;
                    else if (step == SW'(1)) state_c = S_MOV_LOAD;
                    else if (step == SW'(2)) state_c = S_MOV_STORE;
                end
                8'b10??_????: begin
                    if (step == SW'(0)) state_c = S_ALU_OP;
                end
                default: state_c = S_NEXT;
            endcase
        end
    end

    // Next cycle count and program counter.
    always_comb begin
        cycle_d = cycle_q + SW'(1);
        pc_d    = pc_q;
        if (state_c == S_NEXT) begin
            cycle_d = SW'(0);
        end else if (state_c == S_HALT) begin
            cycle_d = cycle_q;
        end
        case (state_c)
            S_FETCH_INST, S_LOAD_ADDR, S_LDI: pc_d = pc_q + DW'(1);
            S_MOV_LOAD: if (mov_memory) pc_d = pc_q + DW'(1);
            S_JUMP:     pc_d = jump_allowed ? bus_in : pc_q + DW'(1);
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            pc_q    <= '0;
        end else begin
            cycle_q <= cycle_d;
            pc_q    <= pc_d;
        end
    end

    // ALU: 9-bit result so bit 8 doubles as carry / no-borrow.
    always_comb begin
        alu_res = '0;
        case (opcode[5:3])
            3'b000:  alu_res = {1'b0, rega} + {1'b0, regb} + (DW+1)'(cin);
            3'b001:  alu_res = {1'b0, rega} + {1'b0, ~regb} + (DW+1)'(1);
            3'b010:  alu_res = {1'b0, rega & regb};
            3'b011:  alu_res = {1'b0, rega | regb};
            3'b100:  alu_res = {1'b0, rega ^ regb};
            3'b101:  alu_res = {1'b0, ~rega};
            3'b110:  alu_res = {1'b0, rega} + (DW+1)'(1);
            default: alu_res = {1'b0, rega} - (DW+1)'(1);
        endcase
    end

    assign state   = state_c;
    assign cycle   = cycle_q;
    assign pc      = pc_q;
    assign alu_out = alu_res[DW-1:0];
    assign cout    = alu_res[DW];

endmodule

// File: tb/tb_cpu_seq_core.sv
// Bench for cpu_seq_core: directed and randomized instructions against a per-instruction
// state-list model, plus an arithmetic ALU model.
module tb_cpu_seq_core;

    logic       clk;
    logic       reset;
    logic [7:0] opcode;
    logic [7:0] bus_in;
    logic [7:0] rega;
    logic [7:0] regb;
    logic       cin;
    logic [3:0] state;
    logic [3:0] cycle;
    logic [7:0] pc;
    logic [7:0] alu_out;
    logic       cout;
    logic       eq_zero;
    logic       jump_allowed;

    int         vectors;
    int         miscompares;
    logic [7:0] mpc;
    int         exp_seq[$];

    cpu_seq_core dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .bus_in       (bus_in),
        .rega         (rega),
        .regb         (regb),
        .cin          (cin),
        .state        (state),
        .cycle        (cycle),
        .pc           (pc),
        .alu_out      (alu_out),
        .cout         (cout),
        .eq_zero      (eq_zero),
        .jump_allowed (jump_allowed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected micro-state list of one instruction, written straight from the opcode table.
    function automatic void build_seq(input logic [7:0] op);
        exp_seq.delete();
        exp_seq.push_back(0);
        exp_seq.push_back(1);
        if (op == 8'h00) begin
            exp_seq.push_back(15);
        end else if (op == 8'h01 || op == 8'h02 || op == 8'h03) begin
            exp_seq.push_back(0);
            exp_seq.push_back(3);
            exp_seq.push_back(op == 8'h01 ? 4 : (op == 8'h02 ? 5 : 6));
            exp_seq.push_back(15);
        end else if (op == 8'h04) begin
            exp_seq.push_back(8);
            exp_seq.push_back(15);
        end else if (op == 8'h06 || op == 8'h07 || op == 8'h08) begin
            exp_seq.push_back(0);
            exp_seq.push_back(9);
            exp_seq.push_back(15);
        end else if (op[7:3] == 5'b00010) begin
            exp_seq.push_back(0);
            exp_seq.push_back(10);
            exp_seq.push_back(15);
        end else if (op[7:6] == 2'b01) begin
            exp_seq.push_back(11);
            exp_seq.push_back(12);
            exp_seq.push_back(13);
            exp_seq.push_back(15);
        end else if (op[7:6] == 2'b10) begin
            exp_seq.push_back(7);
            exp_seq.push_back(15);
        end else begin
            exp_seq.push_back(15);
        end
    endfunction

    // Integer-arithmetic ALU reference; DEC carry is left unchecked.
    task automatic alu_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic [2:0] m);
        int ai;
        int bi;
        int r;
        int co;
        bit chk_co;
        ai = int'(a);
        bi = int'(b);
        co = 0;
        chk_co = 1'b1;
        case (m)
            3'd0: begin r = ai + bi + int'(c); co = (r > 255) ? 1 : 0; r = r % 256; end
            3'd1: begin r = ai - bi; co = (ai >= bi) ? 1 : 0; if (r < 0) r = r + 256; end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 255 - ai;
            3'd6: begin r = (ai + 1) % 256; co = (ai == 255) ? 1 : 0; end
            default: begin r = (ai + 255) % 256; chk_co = 1'b0; end
        endcase
        check({tag, "_out"}, 16'(alu_out), 16'(r));
        if (chk_co) check({tag, "_cout"}, 16'(cout), 16'(co));
        check({tag, "_eqz"}, 16'(eq_zero), 16'(ai == 0));
    endtask

    // Runs one full instruction; starts and ends 1 time unit after a rising edge.
    task automatic run_instr(input logic [7:0] op, input logic [7:0] bus, input logic [7:0] a,
                             input logic [7:0] b, input logic c);
        bit taken;
        bit mem;
        opcode = op;
        bus_in = bus;
        rega   = a;
        regb   = b;
        cin    = c;
        build_seq(op);
        taken = (op == 8'h06) || (op == 8'h07 && a == 8'h00) || (op == 8'h08 && a != 8'h00);
        mem   = (op[5:3] == 3'b111) || (op[2:0] == 3'b111);
        for (int i = 0; i < exp_seq.size(); i++) begin
            #1;
            check("state", 16'(state), 16'(exp_seq[i]));
            check("cycle", 16'(cycle), 16'(i));
            check("pc", 16'(pc), 16'(mpc));
            if (i == 0) begin
                check("jump_allowed", 16'(jump_allowed), 16'(taken));
                alu_check("alu_instr", a, b, c, op[5:3]);
            end
            case (exp_seq[i])
                1, 3, 10: mpc = mpc + 8'd1;
                12:       if (mem) mpc = mpc + 8'd1;
                9:        mpc = taken ? bus : mpc + 8'd1;
                default:  mpc = mpc;
            endcase
            @(posedge clk);
            #1;
        end
        check("cycle_restart", 16'(cycle), 16'(0));
        check("pc_end", 16'(pc), 16'(mpc));
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] p0;
        vectors     = 0;
        miscompares = 0;
        mpc         = 8'h00;
        reset  = 1'b1;
        opcode = 8'h00;
        bus_in = 8'h00;
        rega   = 8'h00;
        regb   = 8'h00;
        cin    = 1'b0;
        #1;
        check("rst_state", 16'(state), 16'(0));
        check("rst_cycle", 16'(cycle), 16'(0));
        check("rst_pc", 16'(pc), 16'(0));

        // Directed ALU corners, held in reset so the opcode only selects the mode.
        opcode = 8'b10_000_000; rega = 8'd200; regb = 8'd100; cin = 1'b0; #1;
        check("add_out", 16'(alu_out), 16'(44));
        check("add_cout", 16'(cout), 16'(1));
        opcode = 8'b10_001_000; rega = 8'd5; regb = 8'd7; #1;
        check("sub_out", 16'(alu_out), 16'(254));
        check("sub_cout", 16'(cout), 16'(0));
        opcode = 8'b10_010_000; rega = 8'hF0; regb = 8'h3C; #1;
        check("and_out", 16'(alu_out), 16'(8'h30));
        check("and_cout", 16'(cout), 16'(0));
        opcode = 8'b10_111_000; rega = 8'h00; #1;
        check("dec_out", 16'(alu_out), 16'(255));
        check("dec_eqz", 16'(eq_zero), 16'(1));
        for (int k = 0; k < 40; k++) begin
            logic [2:0] m;
            m      = 3'($urandom_range(0, 7));
            opcode = {2'b10, m, 3'($urandom)};
            rega   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            regb   = 8'($urandom);
            cin    = 1'($urandom);
            #1;
            alu_check("alu_rand", rega, regb, cin, m);
        end

        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        check("lda_pc", 16'(pc), 16'(2));

        // Reset in the middle of an LDA.
        opcode = 8'h01;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_cycle", 16'(cycle), 16'(3));
        reset = 1'b1;
        #1;
        check("abort_state", 16'(state), 16'(0));
        check("abort_cycle", 16'(cycle), 16'(0));
        check("abort_pc", 16'(pc), 16'(0));
        @(posedge clk);
        #1;
        check("abort_hold_cycle", 16'(cycle), 16'(0));
        reset = 1'b0;
        mpc   = 8'h00;
        run_instr(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);

        run_instr(8'h07, 8'h40, 8'h00, 8'h00, 1'b0);
        check("jez_taken", 16'(pc), 16'(8'h40));
        run_instr(8'h07, 8'h90, 8'h05, 8'h00, 1'b0);
        check("jez_skip", 16'(pc), 16'(8'h42));
        run_instr(8'h08, 8'h80, 8'h05, 8'h00, 1'b0);
        check("jnz_taken", 16'(pc), 16'(8'h80));
        run_instr(8'h06, 8'hFE, 8'h00, 8'h00, 1'b0);
        check("jmp_taken", 16'(pc), 16'(8'hFE));
        run_instr(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        check("pc_wrap", 16'(pc), 16'(0));

        p0 = pc;
        run_instr(8'b01_000_111, 8'h00, 8'h11, 8'h22, 1'b0);
        check("mov_mem_pc", 16'(pc), 16'(p0 + 8'd2));
        p0 = pc;
        run_instr(8'b01_000_001, 8'h00, 8'h11, 8'h22, 1'b0);
        check("mov_reg_pc", 16'(pc), 16'(p0 + 8'd1));

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 11))
                0:  op = 8'h00;
                1:  op = 8'h01;
                2:  op = 8'h02;
                3:  op = 8'h03;
                4:  op = 8'h04;
                5:  op = 8'h06;
                6:  op = 8'h07;
                7:  op = 8'h08;
                8:  op = {5'b00010, 3'($urandom)};
                9:  op = {2'b01, 6'($urandom)};
                10: op = {2'b10, 6'($urandom)};
                default: op = ($urandom_range(0, 1) == 0) ? 8'(9 + $urandom_range(0, 6))
                                                          : {2'b11, 6'($urandom)};
            endcase
            run_instr(op, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                      8'($urandom), 1'($urandom));
        end

        // HLT freezes everything until reset.
        opcode = 8'h05;
        #1;
        check("hlt_s0", 16'(state), 16'(0));
        @(posedge clk);
        #1;
        check("hlt_s1", 16'(state), 16'(1));
        mpc = mpc + 8'd1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            check("hlt_state", 16'(state), 16'(2));
            check("hlt_cycle", 16'(cycle), 16'(2));
            check("hlt_pc", 16'(pc), 16'(mpc));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("hlt_exit_state", 16'(state), 16'(0));
        check("hlt_exit_pc", 16'(pc), 16'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
